hazard_scoreboard: RTL and testbench

- Parametrised hazard-detection block for the pipelined core. It tracks in-flight register writes between decode issue and writeback, and raises a decode stall on read-after-write conflicts.
- It generalises the fixed two-stage compare (D/E and E/M) to PIPE_DEPTH tracked stages with configurable register count and flush depth.
- It sits beside decode. Its stall output gates the F/D and D/E pipe registers.

---
 rtl/hazard_scoreboard.sv | 147 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: tracks in-flight register writes from decode issue to writeback and stalls decode on conflicts.
// Optional macro HAZARD_SCOREBOARD_FORWARDING_EN: stall only on load-use and expose per-source forwarding selects.

module hazard_scoreboard_slot_cmp #(
    parameter int REG_W = 3
) (
    input  logic                  slot_valid_i,
    input  logic [REG_W-1:0]      slot_wreg_i,
    input  logic [2:0][REG_W-1:0] src_i,
    input  logic [2:0]            src_valid_i,
    output logic [2:0]            match_o
);
    always_comb begin
        match_o = '0;
        for (int s = 0; s < 3; s++) begin
            match_o[s] = slot_valid_i & src_valid_i[s] & (slot_wreg_i == src_i[s]);
        end
    end
endmodule

module hazard_scoreboard #(
    parameter int REG_W       = 3,
    parameter int PIPE_DEPTH  = 2,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              issue_valid,
    input  logic                              issue_wr_en,
    input  logic [REG_W-1:0]                  issue_wreg,
    input  logic                              issue_is_load,
    input  logic [REG_W-1:0]                  rs,
    input  logic [REG_W-1:0]                  rt,
    input  logic [REG_W-1:0]                  rd,
    input  logic                              rs_valid,
    input  logic                              rt_valid,
    input  logic                              rd_valid,
    input  logic                              freeze,
    input  logic                              flush,
    output logic                              stall,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]   occupancy
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
   ,output logic [$clog2(PIPE_DEPTH+1)-1:0]   fwd_rs_sel,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]   fwd_rt_sel,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]   fwd_rd_sel
`endif
);
    localparam int CW = $clog2(PIPE_DEPTH + 1);

    logic [PIPE_DEPTH-1:0]            valid_q, valid_d, live;
    logic [PIPE_DEPTH-1:0][REG_W-1:0] wreg_q, wreg_d;
    logic [PIPE_DEPTH-1:0]            load_q, load_d;
    logic [CW-1:0]                    occ_q, occ_d;

    logic [2:0][REG_W-1:0]            src;
    logic [2:0]                       src_v;
    logic [PIPE_DEPTH-1:0][2:0]       match;
    logic [2:0]                       any_match;
    logic                             accept;

    // Source index 0 = rs, 1 = rt, 2 = rd (store data).
    assign src   = {rd, rt, rs};
    assign src_v = {rd_valid, rt_valid, rs_valid};

    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_slot
        hazard_scoreboard_slot_cmp #(.REG_W(REG_W)) u_cmp (
            .slot_valid_i (valid_q[g]),
            .slot_wreg_i  (wreg_q[g]),
            .src_i        (src),
            .src_valid_i  (src_v),
            .match_o      (match[g])
        );
    end

    always_comb begin
        any_match = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            any_match = any_match | match[i];
        end
    end

`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
    logic [2:0][CW-1:0] sel;

    // Only a load still in the D/E slot cannot be forwarded in time.
    assign stall = ~flush & (|match[0]) & load_q[0];

    always_comb begin
        sel = '0;
        for (int s = 0; s < 3; s++) begin
            // Walk oldest to youngest so the youngest writer wins.
            for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
                if (match[i][s]) sel[s] = CW'(i + 1);
            end
        end
        if (stall || flush) sel = '0;
    end

    assign fwd_rs_sel = sel[0];
    assign fwd_rt_sel = sel[1];
    assign fwd_rd_sel = sel[2];
`else
    assign stall = ~flush & (|any_match);
`endif

    assign accept = issue_valid & ~stall & ~freeze & ~flush;

    // Flushed young slots become bubbles, then the pipe shifts unless frozen.
    always_comb begin
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            live[i] = valid_q[i] & ~(flush && (i < FLUSH_DEPTH));
        end
        valid_d = live;
        wreg_d  = wreg_q;
        load_d  = load_q;
        if (!freeze) begin
            for (int i = PIPE_DEPTH - 1; i >= 1; i--) begin
                valid_d[i] = live[i-1];
                wreg_d[i]  = wreg_q[i-1];
                load_d[i]  = load_q[i-1];
            end
            valid_d[0] = accept & issue_wr_en;
            wreg_d[0]  = issue_wreg;
            load_d[0]  = issue_is_load;
        end
        occ_d = '0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            occ_d = occ_d + CW'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            wreg_q  <= '0;
            load_q  <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wreg_q  <= wreg_d;
            load_q  <= load_d;
            occ_q   <= occ_d;
        end
    end

    assign occupancy = occ_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic against an age-list model.
module tb_hazard_scoreboard;
    localparam int REG_W = 3;
    localparam int PD    = 2;
    localparam int FD    = 1;
    localparam int CW    = $clog2(PD + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic issue_valid = 0, issue_wr_en = 0, issue_is_load = 0;
    logic [REG_W-1:0] issue_wreg = '0, rs = '0, rt = '0, rd = '0;
    logic rs_valid = 0, rt_valid = 0, rd_valid = 0, freeze = 0, flush = 0;
    logic stall;
    logic [CW-1:0] occupancy;
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
    logic [CW-1:0] fwd_rs_sel, fwd_rt_sel, fwd_rd_sel;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_W(REG_W), .PIPE_DEPTH(PD), .FLUSH_DEPTH(FD)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_wr_en   (issue_wr_en),
        .issue_wreg    (issue_wreg),
        .issue_is_load (issue_is_load),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .rs_valid      (rs_valid),
        .rt_valid      (rt_valid),
        .rd_valid      (rd_valid),
        .freeze        (freeze),
        .flush         (flush),
        .stall         (stall),
        .occupancy     (occupancy)
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
       ,.fwd_rs_sel    (fwd_rs_sel),
        .fwd_rt_sel    (fwd_rt_sel),
        .fwd_rd_sel    (fwd_rd_sel)
`endif
    );

    // Model: list of in-flight writes, each with its age in cycles since issue.
    typedef struct {int r; bit ld; int age;} ent_t;
    ent_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int m_hit_age(int s, bit sv);
        int best = -1;
        foreach (q[k]) if (sv && q[k].r == s && (best < 0 || q[k].age < best)) best = q[k].age;
        return best;
    endfunction

    function automatic bit m_stall();
        int a0, a1, a2;
        if (flush) return 0;
        a0 = m_hit_age(int'(rs), rs_valid);
        a1 = m_hit_age(int'(rt), rt_valid);
        a2 = m_hit_age(int'(rd), rd_valid);
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
        foreach (q[k]) if (q[k].age == 0 && q[k].ld && (a0 == 0 || a1 == 0 || a2 == 0)) return 1;
        return 0;
`else
        return (a0 >= 0) || (a1 >= 0) || (a2 >= 0);
`endif
    endfunction

    function automatic int m_fwd(int s, bit sv);
        int a;
        if (flush || m_stall()) return 0;
        a = m_hit_age(s, sv);
        return (a < 0) ? 0 : a + 1;
    endfunction

    task automatic m_edge(input bit st);
        ent_t n[$];
        if (rst) begin
            q.delete();
            return;
        end
        foreach (q[k]) begin
            ent_t e = q[k];
            if (flush && e.age < FD) continue;
            if (!freeze) e.age++;
            if (e.age < PD) n.push_back(e);
        end
        if (!freeze && !flush && issue_valid && !st && issue_wr_en)
            n.push_back('{int'(issue_wreg), issue_is_load, 0});
        q = n;
    endtask

    // One clock: check combinational outputs mid-cycle, advance model at the edge, check occupancy after.
    task automatic cyc();
        bit st;
        @(negedge clk);
        st = m_stall();
        if (!rst) begin
            chk("stall", stall, st);
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
            chk("fwd_rs", fwd_rs_sel, m_fwd(int'(rs), rs_valid));
            chk("fwd_rt", fwd_rt_sel, m_fwd(int'(rt), rt_valid));
            chk("fwd_rd", fwd_rd_sel, m_fwd(int'(rd), rd_valid));
`endif
        end
        @(posedge clk);
        m_edge(st);
        #1;
        chk("occupancy", occupancy, q.size());
    endtask

    task automatic idle();
        issue_valid = 0; issue_wr_en = 0; issue_is_load = 0; issue_wreg = '0;
        rs = '0; rt = '0; rd = '0; rs_valid = 0; rt_valid = 0; rd_valid = 0;
        freeze = 0; flush = 0;
    endtask

    task automatic issue(input int r, input bit ld);
        idle();
        issue_valid = 1; issue_wr_en = 1; issue_wreg = REG_W'(r); issue_is_load = ld;
    endtask

    initial begin
        idle();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
        rs = 3; rs_valid = 1;
        #1;
        chk("reset_stall", stall, 0);
        chk("reset_occ", occupancy, 0);
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
        chk("reset_fwd", fwd_rs_sel, 0);
`endif
        cyc();

`ifndef HAZARD_SCOREBOARD_FORWARDING_EN
        // RAW interlock
        issue(2, 0); cyc();
        idle(); rs = 2; rs_valid = 1;
        #1; chk("raw_stall_c0", stall, 1); cyc(); chk("raw_occ_c0", occupancy, 1);
        #1; chk("raw_stall_c1", stall, 1); cyc(); chk("raw_occ_c1", occupancy, 0);
        #1; chk("raw_stall_c2", stall, 0); cyc();
        // flush kills the youngest slot and masks stall
        issue(5, 0); cyc();
        idle(); flush = 1; rt = 5; rt_valid = 1;
        #1; chk("flush_stall", stall, 0); cyc(); chk("flush_occ", occupancy, 0);
        idle(); cyc();
        // freeze holds the scoreboard
        issue(4, 0); cyc();
        idle(); freeze = 1; rs = 4; rs_valid = 1;
        for (int k = 0; k < 3; k++) begin
            #1; chk("frz_stall", stall, 1); cyc(); chk("frz_occ", occupancy, 1);
        end
        freeze = 0;
        #1; chk("frz_rel0", stall, 1); cyc();
        #1; chk("frz_rel1", stall, 1); cyc();
        #1; chk("frz_rel2", stall, 0); cyc();
        // store-data hazard on rd
        issue(6, 0); cyc();
        idle(); rd = 6; rd_valid = 1;
        #1; chk("st_stall", stall, 1);
        rd_valid = 0;
        #1; chk("st_nostall", stall, 0);
        cyc(); cyc();
`else
        issue(1, 0); cyc();
        idle(); rs = 1; rs_valid = 1;
        #1; chk("alu_stall", stall, 0); chk("alu_fwd", fwd_rs_sel, 1);
        cyc(); cyc();
        issue(1, 1); cyc();
        idle(); rs = 1; rs_valid = 1;
        #1; chk("ld_stall", stall, 1); cyc();
        #1; chk("ld_stall_clr", stall, 0); chk("ld_fwd", fwd_rs_sel, 2);
        cyc();
`endif

        for (int n = 0; n < 2000; n++) begin
            rst           = ($urandom_range(0, 99) == 0);
            issue_valid   = ($urandom_range(0, 3) != 0);
            issue_wr_en   = ($urandom_range(0, 4) != 0);
            issue_is_load = ($urandom_range(0, 2) == 0);
            issue_wreg    = REG_W'($urandom_range(0, 7));
            rs = REG_W'($urandom_range(0, 7)); rs_valid = $urandom_range(0, 1);
            rt = REG_W'($urandom_range(0, 7)); rt_valid = $urandom_range(0, 1);
            rd = REG_W'($urandom_range(0, 7)); rd_valid = ($urandom_range(0, 3) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            flush  = ($urandom_range(0, 9) == 0);
            cyc();
        end
        rst = 0;
        idle();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
